// File: rtl/delta_batch_accum.sv
// Batches small per-cycle event counts into deltas for the up/down delta counter.
// Optional DELTA_BATCH_STATS_EN adds the batch_cnt_o / evt_drop_o statistics ports.
module delta_batch_accum #(
  parameter int WIDTH    = 4,
  parameter int IN_WIDTH = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                evt_valid_i,
  input  logic [IN_WIDTH-1:0] evt_cnt_i,
  output logic                evt_ready_o,
  input  logic [WIDTH-1:0]    thresh_i,
  input  logic                flush_i,
  output logic                delta_valid_o,
  input  logic                delta_ready_i,
  output logic [WIDTH-1:0]    delta_o,
  output logic                pending_o
`ifdef DELTA_BATCH_STATS_EN
  ,
  output logic [15:0]         batch_cnt_o,
  output logic [0:0]          evt_drop_o
`endif
);

  localparam int EVT_MAX = 2**IN_WIDTH - 1;
  localparam int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Highest accumulator value that still absorbs a worst-case beat without wrapping.
  localparam logic [WIDTH-1:0] ACC_LIM = WIDTH'((2**WIDTH - 1) - EVT_MAX);
  localparam logic [TMR_W-1:0] TMR_MAX = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_vld_q, out_vld_d;

  logic accepted, slot_free, xfer, acc_nz, thr_hit, tmo_hit, launch;
  logic [WIDTH-1:0] beat;

  assign evt_ready_o = (acc_q <= ACC_LIM);
  assign accepted    = evt_valid_i && evt_ready_o;
  assign beat        = accepted ? WIDTH'(evt_cnt_i) : '0;
  assign slot_free   = !out_vld_q || delta_ready_i;
  assign xfer        = out_vld_q && delta_ready_i;
  assign acc_nz      = (acc_q != '0);
  assign thr_hit     = (thresh_i != '0) && (acc_q >= thresh_i);
  assign tmo_hit     = (TIMEOUT != 0) && (tmr_q == TMR_MAX);
  assign launch      = acc_nz && slot_free && (thr_hit || tmo_hit || flush_i);

  always_comb begin
    acc_d     = acc_q;
    tmr_d     = tmr_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (clear_i) begin
      acc_d     = '0;
      tmr_d     = '0;
      out_vld_d = 1'b0;
    end else begin
      if (launch) begin
        out_d     = acc_q;
        out_vld_d = 1'b1;
        acc_d     = beat;
      end else begin
        acc_d = acc_q + beat;
        if (xfer) out_vld_d = 1'b0;
      end
      // Timer saturates at TMR_MAX; a blocked slot leaves it parked there until launch.
      if (TIMEOUT == 0 || launch || !acc_nz) tmr_d = '0;
      else if (tmr_q != TMR_MAX)             tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      tmr_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      tmr_q     <= tmr_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign delta_o       = out_q;
  assign delta_valid_o = out_vld_q;
  assign pending_o     = acc_nz || out_vld_q;

`ifdef DELTA_BATCH_STATS_EN
  logic [15:0] batch_cnt_q, batch_cnt_d;

  always_comb begin
    batch_cnt_d = batch_cnt_q;
    if (clear_i)                             batch_cnt_d = '0;
    else if (xfer && batch_cnt_q != 16'hFFFF) batch_cnt_d = batch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) batch_cnt_q <= '0;
    else         batch_cnt_q <= batch_cnt_d;
  end

  assign batch_cnt_o = batch_cnt_q;
  assign evt_drop_o  = evt_valid_i && !evt_ready_o;
`endif

endmodule

// File: tb/tb_delta_batch_accum.sv
// Directed bench for delta_batch_accum (WIDTH=4, IN_WIDTH=2, TIMEOUT=16).
module tb_delta_batch_accum;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clear_i = 1'b0;
  logic       evt_valid_i = 1'b0;
  logic [1:0] evt_cnt_i = '0;
  logic       evt_ready_o;
  logic [3:0] thresh_i = '0;
  logic       flush_i = 1'b0;
  logic       delta_valid_o;
  logic       delta_ready_i = 1'b1;
  logic [3:0] delta_o;
  logic       pending_o;
`ifdef DELTA_BATCH_STATS_EN
  logic [15:0] batch_cnt_o;
  logic [0:0]  evt_drop_o;
`endif

  int checks = 0;
  int errors = 0;

  delta_batch_accum #(.WIDTH(4), .IN_WIDTH(2), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .evt_valid_i(evt_valid_i), .evt_cnt_i(evt_cnt_i), .evt_ready_o(evt_ready_o),
    .thresh_i(thresh_i), .flush_i(flush_i),
    .delta_valid_o(delta_valid_o), .delta_ready_i(delta_ready_i),
    .delta_o(delta_o), .pending_o(pending_o)
`ifdef DELTA_BATCH_STATS_EN
    , .batch_cnt_o(batch_cnt_o), .evt_drop_o(evt_drop_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic v, input logic [1:0] c);
    evt_valid_i = v;
    evt_cnt_i   = c;
  endtask

  initial begin
    #2;
    check("rst_ready", evt_ready_o, 1);
    check("rst_valid", delta_valid_o, 0);
    check("rst_delta", delta_o, 0);
    check("rst_pending", pending_o, 0);
    #14 rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: threshold 4, one event per cycle
    thresh_i = 4'd4;
    beat(1, 2'd1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("t1_valid", delta_valid_o, (i >= 5 && (i - 5) % 4 == 0) ? 1 : 0);
      if (i >= 5) check("t1_delta", delta_o, 4);
    end
    beat(0, 2'd0);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_pending", pending_o, 0);

    // 2: timeout drains a single beat of 3
    thresh_i = 4'd0;
    beat(1, 2'd3); tick(); beat(0, 2'd0);
    check("t2_pending", pending_o, 1);
    for (int k = 1; k <= 15; k++) tick();
    check("t2_early", delta_valid_o, 0);
    tick();
    check("t2_valid", delta_valid_o, 1);
    check("t2_delta", delta_o, 3);
    tick();
    check("t2_done_valid", delta_valid_o, 0);
    check("t2_done_pend", pending_o, 0);

    // 3: backpressure with threshold 2, three events per cycle
    delta_ready_i = 1'b0;
    thresh_i = 4'd2;
    beat(1, 2'd3);
    tick(); tick();
    check("t3_valid", delta_valid_o, 1);
    check("t3_delta", delta_o, 3);
    tick(); tick(); tick();
    check("t3_ready12", evt_ready_o, 1);
    tick();
    check("t3_ready15", evt_ready_o, 0);
`ifdef DELTA_BATCH_STATS_EN
    check("t3_drop", evt_drop_o, 1);
`endif
    tick(); tick();
    check("t3_hold_valid", delta_valid_o, 1);
    check("t3_hold_delta", delta_o, 3);
    delta_ready_i = 1'b1;
    beat(0, 2'd0);
    tick();
    check("t3_b2b_valid", delta_valid_o, 1);
    check("t3_b2b_delta", delta_o, 15);
    tick();
    check("t3_end_valid", delta_valid_o, 0);
    check("t3_end_pend", pending_o, 0);

    // 4: flush behaviour
    thresh_i = 4'd0;
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("t4_flush0", delta_valid_o, 0);
    beat(1, 2'd2); tick(); beat(0, 2'd0);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("t4_flush_valid", delta_valid_o, 1);
    check("t4_flush_delta", delta_o, 2);
    tick();
    check("t4_idle", delta_valid_o, 0);
    beat(1, 2'd2); tick();
    beat(1, 2'd1); flush_i = 1'b1; tick();
    beat(0, 2'd0);
    check("t4_same_delta", delta_o, 2);
    tick(); flush_i = 1'b0;
    check("t4_carry_valid", delta_valid_o, 1);
    check("t4_carry_delta", delta_o, 1);
    tick();
    check("t4_end_pend", pending_o, 0);

    // 5: clear drops an in-flight delta and a partial batch of 5
    delta_ready_i = 1'b0;
    beat(1, 2'd3); tick(); beat(0, 2'd0);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("t5_valid", delta_valid_o, 1);
    beat(1, 2'd3); tick();
    beat(1, 2'd2); tick();
    beat(0, 2'd0);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("t5_clr_valid", delta_valid_o, 0);
    check("t5_clr_pend", pending_o, 0);
    delta_ready_i = 1'b1;
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("t5_flush", delta_valid_o, 0);

    // 6: async reset mid-batch
    beat(1, 2'd3); tick(); tick(); beat(0, 2'd0);
    check("t6_pre_pend", pending_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_ready", evt_ready_o, 1);
    check("t6_rst_valid", delta_valid_o, 0);
    check("t6_rst_delta", delta_o, 0);
    check("t6_rst_pend", pending_o, 0);
    #2 rst_ni = 1'b1;
    beat(1, 2'd1); tick(); beat(0, 2'd0);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("t6_new_valid", delta_valid_o, 1);
    check("t6_new_delta", delta_o, 1);
    tick();
`ifdef DELTA_BATCH_STATS_EN
    check("t6_batch_cnt", batch_cnt_o, 1);
`endif
    check("t6_end_pend", pending_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
